// File: rtl/playfield_pkg.sv
// Shared types and constants for the playfield controller: game-state encoding,
// the 12-bit RGB colour type and the default palette.
package playfield_pkg;

  typedef logic [11:0] color_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  localparam color_t COL_SHIP    = 12'hfff;
  localparam color_t COL_WALL    = 12'h00f;
  localparam color_t COL_BG      = 12'h000;
  localparam color_t COL_SCORE   = 12'hff0;
  localparam color_t COL_OVER_BG = 12'h400;

endpackage

// File: rtl/layer_priority_mux.sv
// Priority encoder over the object layers: the lowest-index drawn layer supplies
// the colour; hit reports whether any layer is drawn at all.
module layer_priority_mux
  import playfield_pkg::*;
#(
  parameter int NUM_LAYERS = 4
) (
  input  logic [NUM_LAYERS-1:0]    layer_draw,
  input  logic [12*NUM_LAYERS-1:0] layer_color,
  output color_t                   color,
  output logic                     hit
);

  // Scan from the top index down so the lowest set index is written last.
  always_comb begin
    color = '0;
    hit   = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_draw[i]) begin
        color = layer_color[12*i +: 12];
        hit   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/playfield_ctrl.sv
// Playfield controller: pixel compositing with border, frame/move strobes, ship
// collision detection and the game-state FSM. Optional macro HIT_FLASH_EN.
module playfield_ctrl
  import playfield_pkg::*;
#(
  parameter int                  NUM_LAYERS  = 4,
  parameter int                  SHIP_LAYER  = 0,
  parameter logic [NUM_LAYERS-1:0] HAZARD_MASK = 4'b1110,
  parameter bit                  WALL_HAZARD = 1'b1,
  parameter int                  BORDER_L    = 160,
  parameter int                  BORDER_R    = 480,
  parameter int                  BORDER_T    = 10,
  parameter int                  BORDER_B    = 460,
  parameter color_t              WALL_COLOR  = COL_WALL,
  parameter color_t              BG_COLOR    = COL_BG,
  parameter int                  LIVES_INIT  = 3,
  parameter int                  HIT_FRAMES  = 60,
  parameter int                  SCORE_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pixpulse,
  input  logic [9:0]               hcount,
  input  logic [9:0]               vcount,
  input  logic                     hblank,
  input  logic                     vblank,
  input  logic [NUM_LAYERS-1:0]    layer_draw,
  input  logic [12*NUM_LAYERS-1:0] layer_color,
  input  logic                     score_inc,
  input  logic                     start_btn,
  output logic                     move,
  output logic                     frame_tick,
  output logic                     empty,
  output logic [SCORE_W-1:0]       score,
  output logic [2:0]               lives,
  output logic [1:0]               game_state,
  output logic [3:0]               vgaRed,
  output logic [3:0]               vgaGreen,
  output logic [3:0]               vgaBlue
);

  localparam int CNT_W = (HIT_FRAMES > 8) ? $clog2(HIT_FRAMES) : 3;
  localparam logic [CNT_W-1:0]      HIT_LAST  = CNT_W'(HIT_FRAMES - 1);
  localparam logic [2:0]            LIVES0    = 3'(LIVES_INIT);
  localparam logic [SCORE_W-1:0]    SCORE_MAX = '1;
  localparam logic [9:0]            BL = 10'(BORDER_L);
  localparam logic [9:0]            BR = 10'(BORDER_R);
  localparam logic [9:0]            BT = 10'(BORDER_T);
  localparam logic [9:0]            BB = 10'(BORDER_B);
  localparam logic [NUM_LAYERS-1:0] SHIP_BIT = NUM_LAYERS'(1) << SHIP_LAYER;

  state_t             state, state_nx;
  logic [2:0]         lives_nx;
  logic [SCORE_W-1:0] score_nx;
  logic [CNT_W-1:0]   hit_cnt, hit_cnt_nx;
  logic               hit_pend, vblank_d1, start_d, blank_q;
  color_t             pix, pix_nx, mux_color, bg;
  logic               mux_hit, wall, ship_hide, hit_det, start_rise;
  logic [NUM_LAYERS-1:0] draw_vis;

`ifdef HIT_FLASH_EN
  assign ship_hide = (state == ST_HIT) & hit_cnt[2];
  assign bg        = (state == ST_OVER) ? COL_OVER_BG : BG_COLOR;
`else
  assign ship_hide = 1'b0;
  assign bg        = BG_COLOR;
`endif

  assign wall       = (hcount < BL) | (hcount > BR) | (vcount < BT) | (vcount > BB);
  assign draw_vis   = ship_hide ? (layer_draw & ~SHIP_BIT) : layer_draw;
  assign empty      = ~wall & ~|draw_vis;
  assign frame_tick = pixpulse & vblank & ~vblank_d1;
  assign move       = frame_tick & (state == ST_PLAY);
  assign start_rise = start_btn & ~start_d;
  // Collision uses raw draw flags: a blinking ship can still be hit.
  assign hit_det    = layer_draw[SHIP_LAYER] &
                      (|(layer_draw & HAZARD_MASK) | (WALL_HAZARD & wall));

  layer_priority_mux #(.NUM_LAYERS(NUM_LAYERS)) u_mux (
    .layer_draw  (draw_vis),
    .layer_color (layer_color),
    .color       (mux_color),
    .hit         (mux_hit)
  );

  assign pix_nx = wall ? WALL_COLOR : (mux_hit ? mux_color : bg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      score     <= '0;
      lives     <= LIVES0;
      hit_cnt   <= '0;
      hit_pend  <= 1'b0;
      vblank_d1 <= 1'b0;
      start_d   <= 1'b0;
      pix       <= '0;
      blank_q   <= 1'b1;
    end else begin
      state   <= state_nx;
      score   <= score_nx;
      lives   <= lives_nx;
      hit_cnt <= hit_cnt_nx;
      start_d <= start_btn;
      if (pixpulse) begin
        vblank_d1 <= vblank;
        pix       <= pix_nx;
        blank_q   <= hblank | vblank;
      end
      // The FSM consumes hit_pend on this same tick before it clears.
      if (frame_tick)
        hit_pend <= 1'b0;
      else if (pixpulse & ~hblank & ~vblank & hit_det)
        hit_pend <= 1'b1;
    end
  end

  always_comb begin
    state_nx   = state;
    lives_nx   = lives;
    score_nx   = score;
    hit_cnt_nx = hit_cnt;
    if (state == ST_PLAY && score_inc && score != SCORE_MAX)
      score_nx = score + 1'b1;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (start_rise) begin
          state_nx = ST_PLAY;
          score_nx = '0;
          lives_nx = LIVES0;
        end
      end
      ST_PLAY: begin
        if (frame_tick && hit_pend) begin
          if (lives > 3'd1) begin
            lives_nx   = lives - 3'd1;
            hit_cnt_nx = '0;
            state_nx   = ST_HIT;
          end else begin
            lives_nx = 3'd0;
            state_nx = ST_OVER;
          end
        end
      end
      ST_HIT: begin
        if (frame_tick) begin
          if (hit_cnt == HIT_LAST) state_nx = ST_PLAY;
          else                     hit_cnt_nx = hit_cnt + 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign game_state = state;
  assign {vgaRed, vgaGreen, vgaBlue} = blank_q ? 12'h000 : pix;

endmodule

// File: tb/tb_playfield_ctrl.sv
// Bench for playfield_ctrl: rule-level game model checked every cycle, plus
// directed scenarios with literal expectations on a shortened synthetic frame.
module tb_playfield_ctrl;

  logic        clk = 1'b0;
  logic        rst, pixpulse, hblank, vblank, score_inc, start_btn;
  logic [9:0]  hcount, vcount;
  logic [3:0]  layer_draw;
  logic [47:0] layer_color;
  logic        move, frame_tick, empty;
  logic [7:0]  score;
  logic [2:0]  lives;
  logic [1:0]  game_state;
  logic [3:0]  vgaRed, vgaGreen, vgaBlue;

  playfield_ctrl dut (
    .clk(clk), .rst(rst), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
    .hblank(hblank), .vblank(vblank), .layer_draw(layer_draw), .layer_color(layer_color),
    .score_inc(score_inc), .start_btn(start_btn), .move(move), .frame_tick(frame_tick),
    .empty(empty), .score(score), .lives(lives), .game_state(game_state),
    .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int n_ft = 0, n_mv = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Game model: state 0 idle, 1 play, 2 hit, 3 over.
  int         m_state, m_lives, m_score, m_hit_ticks;
  bit         m_pend, m_vb, m_start, ev_ft, ev_rise;
  logic [11:0] m_rgb;

  function automatic bit is_wall(input int h, input int v);
    return (h < 160) || (h > 480) || (v < 10) || (v > 460);
  endfunction

  function automatic logic [11:0] scene_color(input int h, input int v,
                                              input logic [3:0] d, input logic [47:0] c);
    if (is_wall(h, v)) return 12'h00f;
    for (int i = 0; i < 4; i++) if (d[i]) return c[12*i +: 12];
    return 12'h000;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_lives = 3; m_score = 0; m_hit_ticks = 0;
      m_pend = 0; m_vb = 0; m_start = 0; m_rgb = 12'h000;
    end else begin
      ev_ft   = pixpulse && vblank && !m_vb;
      ev_rise = start_btn && !m_start;
      if (m_state == 1 && score_inc && m_score < 255) m_score++;
      case (m_state)
        0, 3: if (ev_rise) begin m_state = 1; m_score = 0; m_lives = 3; end
        1: if (ev_ft && m_pend) begin
             m_lives--;
             m_hit_ticks = 0;
             m_state = (m_lives == 0) ? 3 : 2;
           end
        default: if (ev_ft) begin
             m_hit_ticks++;
             if (m_hit_ticks == 60) m_state = 1;
           end
      endcase
      if (ev_ft) m_pend = 0;
      else if (pixpulse && !hblank && !vblank && layer_draw[0] &&
               ((layer_draw & 4'b1110) != 0 || is_wall(hcount, vcount)))
        m_pend = 1;
      if (pixpulse) begin
        m_rgb = (hblank || vblank) ? 12'h000 : scene_color(hcount, vcount, layer_draw, layer_color);
        m_vb  = vblank;
      end
      m_start = start_btn;
    end
  end

  always @(negedge clk) begin
    if (frame_tick === 1'b1) n_ft++;
    if (move === 1'b1) n_mv++;
    if (cmp_en) begin
      bit eft;
      eft = pixpulse && vblank && !m_vb;
      chk("state", 32'(game_state), m_state);
      chk("lives", 32'(lives), m_lives);
      chk("score", 32'(score), m_score);
      chk("frame_tick", 32'(frame_tick), 32'(eft));
      chk("move", 32'(move), 32'(eft && m_state == 1));
      chk("empty", 32'(empty), 32'(!is_wall(hcount, vcount) && layer_draw == 4'b0));
      chk("rgb", 32'({vgaRed, vgaGreen, vgaBlue}), 32'(m_rgb));
    end
  end

  task automatic pixel(input int h, input int v, input bit hb, input bit vb, input logic [3:0] d);
    @(posedge clk); #1;
    hcount = 10'(h); vcount = 10'(v); hblank = hb; vblank = vb; layer_draw = d; pixpulse = 1'b1;
    @(posedge clk); #1 pixpulse = 1'b0;
    @(posedge clk); #1;
  endtask

  // Short frame: one active pixel, one hblank pixel, two vblank pixels.
  task automatic frame(input int h, input logic [3:0] d);
    pixel(h, 200, 1'b0, 1'b0, d);
    pixel(h, 200, 1'b1, 1'b0, 4'b0);
    pixel(0, 470, 1'b0, 1'b1, 4'b0);
    pixel(0, 470, 1'b0, 1'b1, 4'b0);
  endtask

  task automatic press();
    @(posedge clk); #1 start_btn = 1'b1;
    repeat (2) @(posedge clk);
    #1 start_btn = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 score_inc = 1'b1;
      @(posedge clk); #1 score_inc = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; pixpulse = 1'b0; hblank = 1'b0; vblank = 1'b0; score_inc = 1'b0;
    start_btn = 1'b0; hcount = 10'd300; vcount = 10'd200; layer_draw = 4'b0;
    layer_color = {12'h123, 12'hf0a, 12'h0f0, 12'hfff};
    @(posedge clk); #1 cmp_en = 1'b1;
    @(posedge clk); #1;
    chk("reset_state", 32'(game_state), 0);
    chk("reset_lives", 32'(lives), 3);
    chk("reset_rgb", 32'({vgaRed, vgaGreen, vgaBlue}), 0);
    rst = 1'b0;

    // idle frames: ticks only
    n_ft = 0; n_mv = 0;
    frame(300, 4'b0); frame(300, 4'b0);
    chk("idle_state", 32'(game_state), 0);
    chk("idle_ticks", n_ft, 2);
    chk("idle_moves", n_mv, 0);

    // first hit, collisions ignored during HIT, return to PLAY after 60 ticks
    press();
    chk("start_state", 32'(game_state), 1);
    frame(300, 4'b0011);
    chk("hit1_state", 32'(game_state), 2);
    chk("hit1_lives", 32'(lives), 2);
    repeat (59) frame(300, 4'b0011);
    chk("hit_hold_state", 32'(game_state), 2);
    chk("hit_hold_lives", 32'(lives), 2);
    frame(300, 4'b0);
    chk("hit_exit_state", 32'(game_state), 1);

    // second hit, then wall-hazard hit ends the game
    frame(300, 4'b0011);
    repeat (60) frame(300, 4'b0);
    chk("hit2_lives", 32'(lives), 1);
    frame(100, 4'b0001);
    chk("over_state", 32'(game_state), 3);
    chk("over_lives", 32'(lives), 0);
    n_mv = 0;
    frame(300, 4'b0); frame(300, 4'b0);
    chk("over_moves", n_mv, 0);
    press();
    chk("restart_state", 32'(game_state), 1);
    chk("restart_lives", 32'(lives), 3);
    chk("restart_score", 32'(score), 0);

    // score saturation; start rise in PLAY ignored
    pulses(300);
    chk("score_sat", 32'(score), 255);
    press();
    chk("play_press_state", 32'(game_state), 1);
    chk("play_press_score", 32'(score), 255);

    // compositing priority, wall, blanking
    pixel(200, 100, 1'b0, 1'b0, 4'b0110);
    chk("rgb_layer1", 32'({vgaRed, vgaGreen, vgaBlue}), 32'h0f0);
    pixel(100, 100, 1'b0, 1'b0, 4'b0);
    chk("rgb_wall", 32'({vgaRed, vgaGreen, vgaBlue}), 32'h00f);
    pixel(200, 100, 1'b1, 1'b0, 4'b0110);
    chk("rgb_hblank", 32'({vgaRed, vgaGreen, vgaBlue}), 32'h000);

    // reset in HIT with a pending hit
    frame(300, 4'b0011);
    chk("pre_rst_state", 32'(game_state), 2);
    pixel(300, 200, 1'b0, 1'b0, 4'b0011);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_state", 32'(game_state), 0);
    chk("rst_lives", 32'(lives), 3);
    chk("rst_rgb", 32'({vgaRed, vgaGreen, vgaBlue}), 0);
    rst = 1'b0;
    pulses(5);
    chk("idle_score", 32'(score), 0);
    press();
    frame(300, 4'b0);
    chk("post_rst_state", 32'(game_state), 1);
    chk("post_rst_lives", 32'(lives), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
